// File: rtl/mp_pkg.sv
// Shared constants and state encoding for the 2x2 max-pool window generator.
// Field offsets give the position of each pixel inside a channel lane.
package mp_pkg;

  localparam int CH_DEF = 16;
  localparam int DW_DEF = 8;
  localparam int LANE_W = 4 * DW_DEF;

  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;

  typedef enum logic {
    TOP = 1'b0,
    BOT = 1'b1
  } mp_state_e;

endpackage

// File: rtl/mpwin_line_buf.sv
// Half-width line buffer holding top-row pixel pairs for the window generator.
// One synchronous write port, one combinational read port, storage not reset.
module mpwin_line_buf #(
  parameter int DEPTH = 26,
  parameter int WIDTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mp_window_gen.sv
// Raster-to-2x2-window feeder for the max-pool stage; buffers one even row.
// Optional MPWIN_SOF_ERR_EN adds a sticky o_err for a misplaced in_sof.
module mp_window_gen
  import mp_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int DW    = DW_DEF,
  parameter int IMG_W = 52,
  parameter int IMG_H = 52
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [CH*DW-1:0]    in_data,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [CH*4*DW-1:0]  o_data,
  output logic                o_eof
`ifdef MPWIN_SOF_ERR_EN
  ,
  output logic                o_err
`endif
);

  localparam int PW   = CH * DW;
  localparam int LW   = 4 * DW;
  localparam int OW   = CH * LW;
  localparam int LB_D = IMG_W / 2;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  mp_state_e     state_q, state_d, st_cur;
  logic [PW-1:0] hold_q;
  logic          ov_q;
  logic [OW-1:0] od_q;
  logic          oe_q;

  logic          acc;
  logic          odd_col;
  logic          col_end;
  logic          row_end;
  logic          lb_we;
  logic          win_ld;
  logic [AW-1:0] lb_addr;
  logic [2*PW-1:0] lb_wdata;
  logic [2*PW-1:0] lb_rdata;
  logic [OW-1:0] win;

  assign in_ready = !ov_q || o_ready;
  assign acc      = in_valid && in_ready;

  // A sync beat is processed as pixel (0,0) regardless of the counters.
  always_comb begin
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;
    st_cur  = in_sof ? TOP : state_q;
  end

  assign odd_col  = col_cur[0];
  assign col_end  = (col_cur == COL_LAST);
  assign row_end  = (row_cur == ROW_LAST);
  assign lb_addr  = AW'(col_cur >> 1);
  assign lb_wdata = {in_data, hold_q};
  assign lb_we    = acc && odd_col && (st_cur == TOP);
  assign win_ld   = acc && odd_col && (st_cur == BOT);

  mpwin_line_buf #(
    .DEPTH (LB_D),
    .WIDTH (2 * PW),
    .AW    (AW)
  ) u_lb (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (lb_wdata),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    win = '0;
    for (int k = 0; k < CH; k++) begin
      win[k*LW + TL*DW +: DW] = lb_rdata[k*DW +: DW];
      win[k*LW + TR*DW +: DW] = lb_rdata[PW + k*DW +: DW];
      win[k*LW + BL*DW +: DW] = hold_q[k*DW +: DW];
      win[k*LW + BR*DW +: DW] = in_data[k*DW +: DW];
    end
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (acc) begin
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d   = '0;
          state_d = TOP;
        end else begin
          row_d   = row_cur + RW'(1);
          state_d = (st_cur == TOP) ? BOT : TOP;
        end
      end else begin
        col_d   = col_cur + CW'(1);
        row_d   = row_cur;
        state_d = st_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= TOP;
      hold_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      if (acc && !odd_col) hold_q <= in_data;
      if (win_ld) begin
        ov_q <= 1'b1;
        od_q <= win;
        oe_q <= row_end && col_end;
      end else if (o_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign o_valid = ov_q;
  assign o_data  = od_q;
  assign o_eof   = oe_q;

`ifdef MPWIN_SOF_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (acc && in_sof && (row_q != '0 || col_q != '0)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_mp_window_gen.sv
// Self-checking bench for mp_window_gen at IMG_W=IMG_H=4, CH=16, DW=8.
// A frame-image model builds expected windows from the pooling rules.
module tb_mp_window_gen;

  localparam int CH = 16;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = CH * DW;
  localparam int OW = CH * 4 * DW;

  typedef struct {
    logic [OW-1:0] d;
    logic          eof;
  } win_t;

  typedef struct {
    bit          iv;
    bit          ordy;
    logic [7:0]  pix;
    bit          ev;
    logic [31:0] elane;
    bit          eeof;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [OW-1:0] o_data;
  logic          o_eof;
`ifdef MPWIN_SOF_ERR_EN
  logic          o_err;
`endif

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;
  int n_eof  = 0;
  win_t q[$];
  logic [PW-1:0] img [H][W];
  int mr = 0;
  int mc = 0;
  bit ordy_g = 1'b1;

  mp_window_gen #(
    .CH(CH), .DW(DW), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_eof    (o_eof)
`ifdef MPWIN_SOF_ERR_EN
    ,
    .o_err    (o_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [OW-1:0] act,
                     input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int r, input int c);
    logic [7:0] v;
    v = {4'(r), 4'(c)};
    return {CH{v}};
  endfunction

  // Record one accepted beat in the image and emit a window at odd/odd.
  task automatic model_accept(input bit sof, input logic [PW-1:0] d);
    win_t w;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = d;
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      w.d = '0;
      for (int k = 0; k < CH; k++)
        w.d[k*32 +: 32] = {img[mr][mc][k*8 +: 8], img[mr][mc-1][k*8 +: 8],
                           img[mr-1][mc][k*8 +: 8], img[mr-1][mc-1][k*8 +: 8]};
      w.eof = (mr == H - 1) && (mc == W - 1);
      q.push_back(w);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  task automatic cyc(input bit iv, input bit sof, input logic [PW-1:0] d,
                     input bit ordy, output bit acc);
    bit ev;
    bit er;
    win_t w;
    @(negedge clk);
    in_valid = iv;
    in_sof   = sof;
    in_data  = d;
    o_ready  = ordy;
    #1;
    ev = (q.size() != 0);
    er = !ev || ordy;
    chki("o_valid", int'(o_valid), int'(ev));
    chki("in_ready", int'(in_ready), int'(er));
    if (ev) begin
      chk("o_data", o_data, q[0].d);
      chki("o_eof", int'(o_eof), int'(q[0].eof));
    end
    if (ev && ordy) begin
      w = q.pop_front();
      n_pop++;
      if (w.eof) n_eof++;
    end
    acc = iv && er;
    if (acc) model_accept(sof, d);
  endtask

  task automatic stream(input int r0, input int c0, input int n,
                        input bit gap, input bit sof1);
    int r;
    int c;
    bit acc;
    r = r0;
    c = c0;
    for (int b = 0; b < n; b++) begin
      if (gap) cyc(1'b0, 1'b0, '0, ordy_g, acc);
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++)
        cyc(1'b1, sof1 && (b == 0), pix(r, c), ordy_g, acc);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout r=%0d c=%0d", r, c);
      end
      c++;
      if (c == W) begin
        c = 0;
        r = (r + 1) % H;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b1, acc);
  endtask

  initial begin
    vec_t tbl[18];
    bit acc;
    logic [PW-1:0] rd;

    for (int i = 0; i < 18; i++) begin
      tbl[i].iv    = (i < 16);
      tbl[i].ordy  = 1'b1;
      tbl[i].pix   = {4'(i / 4), 4'(i % 4)};
      tbl[i].ev    = 1'b0;
      tbl[i].elane = '0;
      tbl[i].eeof  = 1'b0;
    end
    tbl[6]  = '{1'b1, 1'b1, 8'h12, 1'b1, 32'h11100100, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h20, 1'b1, 32'h13120302, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 8'h32, 1'b1, 32'h31302120, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h33322322, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    chki("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_data", o_data, '0);
    chki("rst_o_eof", int'(o_eof), 0);
    chki("rst_in_ready", int'(in_ready), 1);
`ifdef MPWIN_SOF_ERR_EN
    chki("rst_o_err", int'(o_err), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Case 1: one frame, exact latency and values from the table
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].iv, 1'b0, tbl[i].iv ? {CH{tbl[i].pix}} : '0,
          tbl[i].ordy, acc);
      chki("tbl_valid", int'(o_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl_lane", o_data, {CH{tbl[i].elane}});
        chki("tbl_eof", int'(o_eof), int'(tbl[i].eeof));
      end
    end

    // Case 2: backpressure on the first window
    stream(0, 0, 6, 1'b0, 1'b0);
    repeat (4) begin
      cyc(1'b1, 1'b0, pix(1, 2), 1'b0, acc);
      chki("bp_in_ready", int'(in_ready), 0);
      chki("bp_valid", int'(o_valid), 1);
      chk("bp_data", o_data, {CH{32'h11100100}});
    end
    stream(1, 2, 2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, acc);
    chk("bp_win02", o_data, {CH{32'h13120302}});
    stream(2, 0, 8, 1'b0, 1'b0);
    drain();

    // Case 3: idle gaps between beats
    n_pop = 0;
    n_eof = 0;
    stream(0, 0, 16, 1'b1, 1'b0);
    drain();
    chki("gap_windows", n_pop, 4);
    chki("gap_eofs", n_eof, 1);

    // Case 4: resync with in_sof at beat (2,1)
    n_pop = 0;
    n_eof = 0;
    stream(0, 0, 9, 1'b0, 1'b0);
    stream(0, 0, 6, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, acc);
    chk("sof_win00", o_data, {CH{32'h11100100}});
`ifdef MPWIN_SOF_ERR_EN
    chki("sof_err", int'(o_err), 1);
`endif
    stream(1, 2, 10, 1'b0, 1'b0);
    drain();
    chki("sof_windows", n_pop, 6);
    chki("sof_eofs", n_eof, 1);

    // Case 5: asynchronous reset with a window pending
    stream(0, 0, 6, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, acc);
    #2;
    reset_n = 1'b0;
    #1;
    chki("arst_valid", int'(o_valid), 0);
    chk("arst_data", o_data, '0);
    chki("arst_in_ready", int'(in_ready), 1);
    q.delete();
    mr = 0;
    mc = 0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    n_pop = 0;
    n_eof = 0;
    stream(0, 0, 16, 1'b0, 1'b0);
    drain();
    chki("arst_windows", n_pop, 4);
    chki("arst_eofs", n_eof, 1);

    // Case 6: two back-to-back frames
    n_pop = 0;
    n_eof = 0;
    stream(0, 0, 32, 1'b0, 1'b0);
    drain();
    chki("b2b_windows", n_pop, 8);
    chki("b2b_eofs", n_eof, 2);

    // Random valid/ready/data with occasional resync
    for (int i = 0; i < 800; i++) begin
      for (int j = 0; j < PW / 32; j++) rd[j*32 +: 32] = $urandom();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, rd,
          $urandom_range(0, 2) != 0, acc);
    end
    drain();
    chki("rnd_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
